// File: rtl/input_conditioner_pkg.sv
// ============================================================================
// input_conditioner_pkg: shared types and helpers for the input conditioner.
// Rev 1.0
// ============================================================================
`default_nettype none

package input_conditioner_pkg;

    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } deb_state_t;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_channel.sv
// ============================================================================
// debounce_channel: one-bit synchronizer, debouncer and edge/event flag logic.
// Rev 1.0
// ============================================================================
`default_nettype none

module debounce_channel
    import input_conditioner_pkg::*;
#(
    parameter int   DEPTH           = 3,
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic INVERT          = 1'b0,
    parameter logic RESET_VALUE     = 1'b0
) (
    input  logic clk_in,
    input  logic reset_n_in,
    input  logic signal_in,
    input  logic clear_in,
    output logic signal_out,
    output logic rise_out,
    output logic fall_out,
    output logic event_out
);

    localparam int             CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [DEPTH-1:0] chain_q, chain_d;
    deb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             event_q, event_d;
    logic             sync;
    logic             accept;

    always_comb begin
        chain_d = {chain_q[DEPTH-2:0], signal_in};
        sync    = chain_q[DEPTH-1] ^ INVERT;
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;

        case (state_q)
            STABLE: begin
                if (sync != level_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        accept = 1'b1;
                    end else begin
                        state_d = COUNTING;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            COUNTING: begin
                // Any sample matching the accepted level restarts the run.
                if (sync == level_q) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    accept = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase

        if (accept) begin
            state_d = STABLE;
            cnt_d   = '0;
        end

        level_d = accept ? sync : level_q;
        rise_d  = accept & sync;
        fall_d  = accept & ~sync;
        // A new edge outranks a clear arriving on the same cycle.
        event_d = accept | (event_q & ~clear_in);
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            chain_q <= {DEPTH{RESET_VALUE}};
            state_q <= STABLE;
            cnt_q   <= '0;
            level_q <= RESET_VALUE;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            event_q <= 1'b0;
        end else begin
            chain_q <= chain_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            event_q <= event_d;
        end
    end

    assign signal_out = level_q;
    assign rise_out   = rise_q;
    assign fall_out   = fall_q;
    assign event_out  = event_q;

endmodule

`default_nettype wire

// File: rtl/input_conditioner.sv
// ============================================================================
// input_conditioner: WIDTH independent synchronize/debounce/edge-detect lanes.
// Rev 1.0
// ============================================================================
`default_nettype none

module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               DEPTH           = 3,
    parameter int               DEBOUNCE_CYCLES = 16,
    parameter logic [WIDTH-1:0] INVERT_MASK     = '0,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clk_in,
    input  logic             reset_n_in,
    input  logic [WIDTH-1:0] signal_in,
    input  logic [WIDTH-1:0] clear_in,
    output logic [WIDTH-1:0] signal_out,
    output logic [WIDTH-1:0] rise_out,
    output logic [WIDTH-1:0] fall_out,
    output logic [WIDTH-1:0] event_out
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .DEPTH           (DEPTH),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .INVERT          (INVERT_MASK[i]),
            .RESET_VALUE     (RESET_VALUE[i])
        ) u_chan (
            .clk_in     (clk_in),
            .reset_n_in (reset_n_in),
            .signal_in  (signal_in[i]),
            .clear_in   (clear_in[i]),
            .signal_out (signal_out[i]),
            .rise_out   (rise_out[i]),
            .fall_out   (fall_out[i]),
            .event_out  (event_out[i])
        );
    end

endmodule

`default_nettype wire
